// File: rtl/clk_div_gen_pkg.sv
// clk_div_gen_pkg: shared constants and helpers for the clock divider slice.
// Optional build macro used by the top: CLK_DIV_RST_SYNC_EN.
package clk_div_gen_pkg;

    // Reset half-period: 1 -> divide by 4 (25 MHz from 100 MHz).
    localparam int DEF_HALF_DFLT = 1;

    // Channel-select width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_gen_if.sv
// clk_div_gen_if: divide-ratio write port (strobe, channel, half value) with
// ack/err response pulses and per-channel pending-ratio flags.
interface clk_div_gen_if
    import clk_div_gen_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 6
);
    localparam int CH_W = ch_width(NUM_CH);

    logic              cfg_wr;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_ack;
    logic              cfg_err;
    logic [NUM_CH-1:0] cfg_busy;

    modport master (
        output cfg_wr, cfg_ch, cfg_half,
        input  cfg_ack, cfg_err, cfg_busy
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_half,
        output cfg_ack, cfg_err, cfg_busy
    );

endinterface

// File: rtl/clk_div_gen_channel.sv
// clk_div_gen_channel: one 50%-duty divider channel.
// Ports: clk/rst_n, en (run enable), wr/wr_half (pending ratio load),
// busy (ratio pending), clk_out (divided clock), tick (rise strobe).
module clk_div_gen_channel #(
    parameter int CNT_W    = 6,
    parameter int DEF_HALF = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             busy,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] pend;
    logic             run;
    logic             active;
    logic             at_top;
    logic             bnd;
    logic             apply;

    // run keeps a started period going after en drops, until its 1->0 toggle.
    assign active = en | run;
    assign at_top = (cnt == half);
    assign bnd    = active & at_top & clk_out;
    // Ratios only change at a period boundary, or at once when idle.
    assign apply  = busy & (bnd | ~active);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            half    <= CNT_W'(DEF_HALF);
            pend    <= '0;
            busy    <= 1'b0;
            run     <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (active) begin
                tick <= at_top & ~clk_out;
                if (at_top) begin
                    cnt     <= '0;
                    clk_out <= ~clk_out;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                run <= bnd ? en : 1'b1;
            end else begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                run     <= 1'b0;
            end

            if (apply) begin
                half <= pend;
            end

            // A write landing on a boundary becomes the next pending value.
            if (wr) begin
                pend <= wr_half;
                busy <= 1'b1;
            end else if (apply) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH runtime-programmable, glitch-free clock dividers.
// Ports: clk_from_FPGA, rst_from_FPGA (async active-low), ch_en, cfg (write
// port), clk_out, tick. Macro CLK_DIV_RST_SYNC_EN adds a reset synchroniser.
module clk_div_gen
    import clk_div_gen_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int CNT_W    = 6,
    parameter int DEF_HALF = DEF_HALF_DFLT
) (
    input  logic              clk_from_FPGA,
    input  logic              rst_from_FPGA,
    input  logic [NUM_CH-1:0] ch_en,
    clk_div_gen_if.slave      cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int CH_W = ch_width(NUM_CH);
    localparam logic [CH_W:0] CH_LIM = (CH_W+1)'(NUM_CH);

    logic              rst_n;
    logic              valid;
    logic              ack_q;
    logic              err_q;
    logic [NUM_CH-1:0] busy;

`ifdef CLK_DIV_RST_SYNC_EN
    logic [1:0] rst_sync;

    // Asynchronous assert, release after two clock edges.
    always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
        if (!rst_from_FPGA) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];
`else
    assign rst_n = rst_from_FPGA;
`endif

    assign valid = ({1'b0, cfg.cfg_ch} < CH_LIM);

    always_ff @(posedge clk_from_FPGA or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= cfg.cfg_wr & valid;
            err_q <= cfg.cfg_wr & ~valid;
        end
    end

    assign cfg.cfg_ack  = ack_q;
    assign cfg.cfg_err  = err_q;
    assign cfg.cfg_busy = busy;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;

        assign sel = cfg.cfg_wr & valid & (cfg.cfg_ch == CH_W'(i));

        clk_div_gen_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clk     (clk_from_FPGA),
            .rst_n   (rst_n),
            .en      (ch_en[i]),
            .wr      (sel),
            .wr_half (cfg.cfg_half),
            .busy    (busy[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
